// File: rtl/sprite_word_fetcher_if.sv
// Control, RAM-side and stream-side signals of the sprite word fetcher.
// master = the fetcher, slave = the surrounding system (RAM, renderer, CPU).
interface sprite_word_fetcher_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 11
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  word_count;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_write;
    logic [3:0]        mem_byteenable;
    logic              mem_clken;
    logic [DATA_W-1:0] mem_readdata;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        input  start, base_addr, word_count, mem_readdata, out_ready,
        output busy, done, mem_address, mem_chipselect, mem_write,
        output mem_byteenable, mem_clken, out_data, out_valid, out_last
    );

    modport slave (
        output start, base_addr, word_count, mem_readdata, out_ready,
        input  busy, done, mem_address, mem_chipselect, mem_write,
        input  mem_byteenable, mem_clken, out_data, out_valid, out_last
    );
endinterface

// File: rtl/sprite_word_fetcher.sv
// Avalon-MM read master: streams a block of RAM words through a small
// first-word-fall-through FIFO, issuing reads only when a FIFO slot is free.
module sprite_word_fetcher #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int LEN_W      = 11,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    sprite_word_fetcher_if.master bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_issued;
    logic [LEN_W-1:0]  r_popped;
    logic              r_inflight;
    logic              r_done;
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_fcount;

    logic              w_accept;
    logic              w_zero_start;
    logic              w_push;
    logic              w_pop;
    logic              w_valid;
    logic              w_more;
    logic              w_credit;
    logic              w_issue;
    logic              w_busy;
    logic              w_last_issue;
    logic              w_last_pop;
    logic [CNT_W:0]    w_need;

    assign w_accept     = (r_state == S_IDLE) && bus.start
                          && (bus.word_count != '0);
    assign w_zero_start = (r_state == S_IDLE) && bus.start
                          && (bus.word_count == '0);
    assign w_valid      = (r_fcount != '0);
    assign w_push       = r_inflight;
    assign w_pop        = w_valid && bus.out_ready;
    assign w_more       = (r_issued != r_len);

    // Occupancy once this cycle's pop is gone and the new read has landed.
    assign w_need = {1'b0, r_fcount}
                  + {{CNT_W{1'b0}}, r_inflight}
                  + (CNT_W+1)'(1)
                  - {{CNT_W{1'b0}}, w_pop};
    assign w_credit = (w_need <= (CNT_W+1)'(FIFO_DEPTH));

    assign w_last_issue = w_issue && (r_issued == r_len - LEN_W'(1));
    assign w_last_pop   = w_pop && (r_popped == r_len - LEN_W'(1));

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_accept)     w_next = S_FETCH;
            S_FETCH: if (w_last_issue) w_next = S_DRAIN;
            S_DRAIN: if (w_last_pop)   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy  = 1'b0;
        w_issue = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                w_busy  = 1'b1;
                w_issue = w_more && w_credit;
            end
            S_DRAIN: w_busy = 1'b1;
            default: begin
                w_busy  = 1'b0;
                w_issue = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr     <= '0;
            r_len      <= '0;
            r_issued   <= '0;
            r_popped   <= '0;
            r_inflight <= 1'b0;
            r_done     <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fcount   <= '0;
        end else begin
            r_done     <= w_zero_start
                          || ((r_state == S_DRAIN) && w_last_pop);
            r_inflight <= w_issue;
            if (w_accept) begin
                r_addr   <= bus.base_addr;
                r_len    <= bus.word_count;
                r_issued <= '0;
                r_popped <= '0;
            end else begin
                if (w_issue) begin
                    r_addr   <= r_addr + ADDR_W'(1);
                    r_issued <= r_issued + LEN_W'(1);
                end
                if (w_pop) r_popped <= r_popped + LEN_W'(1);
            end
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop)
                r_fcount <= r_fcount + CNT_W'(1);
            else if (!w_push && w_pop)
                r_fcount <= r_fcount - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= bus.mem_readdata;
    end

    assign bus.busy           = w_busy;
    assign bus.done           = r_done;
    assign bus.mem_address    = r_addr;
    assign bus.mem_chipselect = w_issue;
    assign bus.mem_write      = 1'b0;
    assign bus.mem_byteenable = 4'hF;
    assign bus.mem_clken      = 1'b1;
    assign bus.out_valid      = w_valid;
    assign bus.out_data       = w_valid ? r_mem[r_rd_ptr] : '0;
    assign bus.out_last       = w_valid && (r_popped == r_len - LEN_W'(1));
endmodule

// File: tb/tb_sprite_word_fetcher.sv
// Bench for sprite_word_fetcher: RAM model, stream monitor and a block-level
// reference (word i of a block is RAM[(base+i) mod 1024]).
module tb_sprite_word_fetcher;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 11;
    localparam int DEPTH  = 4;

    typedef struct {
        int base;
        int n;
        int mode;
        int exp_busy;
        int exp_stall;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   cyc;

    logic [31:0] ram [1024];

    int   rd_q[$];
    logic [31:0] rx_q[$];
    logic lst_q[$];
    int   busy_cyc;
    int   done_cnt;
    int   done_cyc;
    int   last_xfer_cyc;
    int   ovf_err;
    int   stab_err;
    int   tie_err;
    bit   hold_pend;
    logic [31:0] hold_data;

    sprite_word_fetcher_if #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)
    ) bus ();

    sprite_word_fetcher #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    always @(posedge clk)
        if (bus.mem_chipselect) bus.mem_readdata <= ram[bus.mem_address];

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.busy) busy_cyc++;
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (bus.mem_chipselect) rd_q.push_back(int'(bus.mem_address));
            if (bus.mem_write || bus.mem_byteenable != 4'hF || !bus.mem_clken)
                tie_err++;
            if (hold_pend && (!bus.out_valid || bus.out_data !== hold_data))
                stab_err++;
            hold_pend = bus.out_valid && !bus.out_ready;
            hold_data = bus.out_data;
            if (bus.out_valid && bus.out_ready) begin
                rx_q.push_back(bus.out_data);
                lst_q.push_back(bus.out_last);
                last_xfer_cyc = cyc;
            end
            if (rd_q.size() - rx_q.size() > DEPTH) ovf_err++;
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        rd_q.delete();
        rx_q.delete();
        lst_q.delete();
        busy_cyc      = 0;
        done_cnt      = 0;
        done_cyc      = -1;
        last_xfer_cyc = -1;
        ovf_err       = 0;
        stab_err      = 0;
        tie_err       = 0;
        hold_pend     = 0;
    endtask

    task automatic ready_for(input int mode, input int k);
        if (mode == 1)      bus.out_ready = 1'($urandom_range(0, 1));
        else if (mode == 2) bus.out_ready = (k >= 10);
        else                bus.out_ready = 1'b1;
    endtask

    // mode: 0 ready high, 1 random ready, 2 stall 10 cycles, 3 restart pulse
    task automatic run_xfer(input int base, input int n, input int mode,
                            input int exp_busy, input int exp_stall);
        int  start_cyc;
        int  stall_reads;
        int  m;
        bit  got;
        clear_mon();
        bus.base_addr  = ADDR_W'(base);
        bus.word_count = LEN_W'(n);
        bus.start      = 1'b1;
        ready_for(mode, 0);
        start_cyc = cyc;
        @(posedge clk); #1;
        bus.start      = 1'b0;
        bus.base_addr  = 10'h3A5;
        bus.word_count = 11'd7;
        got = 0;
        stall_reads = -1;
        for (int k = 1; k < 4000 && !got; k++) begin
            ready_for(mode, k);
            if (mode == 3 && k == 3) begin
                bus.start      = 1'b1;
                bus.base_addr  = 10'h200;
                bus.word_count = 11'd3;
            end else begin
                bus.start = 1'b0;
            end
            if (mode == 2 && k == 10) stall_reads = rd_q.size();
            @(posedge clk); #1;
            if (done_cnt != 0) got = 1;
        end
        bus.start = 1'b0;
        bus.out_ready = 1'b1;
        if (!got) chk("done_timeout", 64'd0, 64'd1);
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("done_count", done_cnt, 1);
        if (n == 0) chk("done_time", done_cyc, start_cyc + 1);
        else        chk("done_time", done_cyc, last_xfer_cyc + 1);
        if (exp_busy >= 0)  chk("busy_cycles", busy_cyc, exp_busy);
        if (exp_stall >= 0) chk("stall_reads", stall_reads, exp_stall);
        chk("busy_after", bus.busy, 0);
        chk("read_count", rd_q.size(), n);
        chk("word_count", rx_q.size(), n);
        m = (rx_q.size() < n) ? rx_q.size() : n;
        for (int i = 0; i < m; i++) begin
            chk($sformatf("data[%0d]", i), rx_q[i], ram[(base + i) % 1024]);
            chk($sformatf("last[%0d]", i), lst_q[i], (i == n - 1));
        end
        m = (rd_q.size() < n) ? rd_q.size() : n;
        for (int i = 0; i < m; i++)
            chk($sformatf("addr[%0d]", i), rd_q[i], (base + i) % 1024);
        chk("fifo_credit", ovf_err, 0);
        chk("hold_stable", stab_err, 0);
        chk("tie_offs", tie_err, 0);
    endtask

    vec_t vecs [8];

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        clear_mon();
        vecs[0] = '{base: 'h010, n: 4,    mode: 0, exp_busy: 6,    exp_stall: -1};
        vecs[1] = '{base: 'h3FE, n: 4,    mode: 0, exp_busy: 6,    exp_stall: -1};
        vecs[2] = '{base: 'h100, n: 8,    mode: 2, exp_busy: -1,   exp_stall: 4};
        vecs[3] = '{base: 'h050, n: 0,    mode: 0, exp_busy: 0,    exp_stall: -1};
        vecs[4] = '{base: 'h080, n: 6,    mode: 3, exp_busy: 8,    exp_stall: -1};
        vecs[5] = '{base: 'h3FF, n: 1,    mode: 0, exp_busy: 3,    exp_stall: -1};
        vecs[6] = '{base: 'h000, n: 1024, mode: 0, exp_busy: 1026, exp_stall: -1};
        vecs[7] = '{base: 'h123, n: 20,   mode: 1, exp_busy: -1,   exp_stall: -1};
        for (int i = 0; i < 1024; i++) ram[i] = $urandom;

        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.base_addr  = '0;
        bus.word_count = '0;
        bus.out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {bus.busy, bus.done, bus.mem_chipselect,
                            bus.mem_address, bus.out_valid, bus.out_last,
                            bus.out_data}, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 8; v++)
            run_xfer(vecs[v].base, vecs[v].n, vecs[v].mode,
                     vecs[v].exp_busy, vecs[v].exp_stall);

        for (int r = 0; r < 6; r++)
            run_xfer(int'($urandom_range(0, 1023)),
                     int'($urandom_range(1, 40)), 1, -1, -1);

        // Abort a 16-word block after its fifth word.
        clear_mon();
        bus.base_addr  = 10'h040;
        bus.word_count = 11'd16;
        bus.start      = 1'b1;
        bus.out_ready  = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int k = 0; k < 100 && rx_q.size() < 5; k++) begin
            @(posedge clk); #1;
        end
        chk("abort_point", rx_q.size(), 5);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_outputs", {bus.busy, bus.done, bus.mem_chipselect,
                              bus.mem_address, bus.out_valid, bus.out_last,
                              bus.out_data}, 64'd0);
        reset = 1'b0;
        clear_mon();
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("abort_no_done", done_cnt, 0);
        chk("abort_no_reads", rd_q.size(), 0);
        chk("abort_idle", bus.busy, 0);
        run_xfer('h020, 2, 0, 4, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
